uart_frame_parser: RTL and testbench
====================================

// Module: uart_frame_parser
// PURPOSE
//  Sits directly downstream of the UART receiver. Consumes its byte strobe (rx_ok) and byte (rx_dat).
//  Assembles framed commands of the form SYNC, LEN, PAYLOAD[LEN], CHK and checks their length and checksum.
//  Holds each good payload in an internal buffer until the command decoder reads it and acknowledges it.
//  Reports checksum, length, inter-byte timeout and overrun errors.
// PARAMETERS
//  MAX_LEN     16       max payload bytes; buffer depth; LEN valid range is 1..MAX_LEN
//  AW          4        rd_addr width, clog2(MAX_LEN)
//  SYNC_BYTE   8'hA5    frame start marker
//  TIMEOUT_CYC 250000   max clk cycles between bytes inside a frame (10 ms at 25 MHz)
// PORTS
//  clk        in   1     system clock
//  rstn       in   1     asynchronous active-low reset
//  rx_dat     in   8     received byte from UART receiver
//  rx_ok      in   1     byte-valid strobe from UART receiver
//  rd_addr    in   AW    payload buffer read index
//  rd_dat     out  8     payload byte at rd_addr; combinational read
//  frm_len    out  AW+1  LEN of the held frame
//  frm_valid  out  1     a good frame is held in the buffer
//  frm_ack    in   1     consumer releases the held frame
//  busy       out  1     high while a frame is in progress (any state except S_IDLE and S_DONE)
//  err_chk    out  1     1-cycle pulse: checksum mismatch
//  err_len    out  1     1-cycle pulse: LEN=0 or LEN>MAX_LEN
//  err_to     out  1     1-cycle pulse: inter-byte timeout
//  err_ovr    out  1     1-cycle pulse: byte arrived while in S_DONE; the byte is dropped
//  frm_cnt    out  8     count of good frames; wraps 255->0
//  err_cnt    out  8     count of all error pulses; saturates at 255
// BEHAVIOUR
//  Reset (async, rstn=0): state=S_IDLE; all outputs 0; buffer cleared to 0; timeout counter 0.
//   The same applies when reset is asserted mid-frame.
//  Byte event: rx_ok registered into rx_ok_d; byte_evt = rx_ok & ~rx_ok_d.
//   One byte is accepted per rising edge of rx_ok, even if rx_ok stays high for several cycles.
//  All outputs except rd_dat are registered. Their effect appears the cycle after byte_evt.
//  FSM:
//   S_IDLE: on byte_evt with rx_dat==SYNC_BYTE, go to S_LEN. Any other byte is ignored silently.
//   S_LEN: on byte_evt with LEN in 1..MAX_LEN: latch LEN, chk=LEN, idx=0, go to S_DATA.
//     Otherwise pulse err_len and go to S_IDLE.
//   S_DATA: on byte_evt: buf[idx]=rx_dat, chk^=rx_dat, idx++. When idx reaches LEN, go to S_CHK.
//   S_CHK: on byte_evt with rx_dat==chk: frm_len=LEN, frm_valid=1, frm_cnt++, go to S_DONE.
//     On mismatch: pulse err_chk and go to S_IDLE; frm_valid stays 0.
//   S_DONE: frm_valid=1 and the buffer is frozen.
//     frm_ack=1: next cycle frm_valid=0 and state=S_IDLE.
//     byte_evt: pulse err_ovr and drop the byte. This also applies when byte_evt and frm_ack occur in the same cycle.
//  frm_ack outside S_DONE is ignored.
//  Checksum is the 8-bit XOR of LEN and all payload bytes. SYNC is not included.
//  Timeout (S_LEN, S_DATA, S_CHK only):
//   Counter clears on every byte_evt and on entry to the state.
//   When the counter reaches TIMEOUT_CYC-1 with no byte_evt, pulse err_to and go to S_IDLE. Buffer contents are not valid afterwards.
//   A byte_evt in the same cycle as the timeout wins: the byte is processed and no err_to is raised.
//  err_cnt increments on each err_* pulse and holds at 255. Only one error can pulse per cycle.
//  A SYNC_BYTE value inside S_LEN, S_DATA or S_CHK is treated as ordinary data. There is no resync.
//  rd_dat = buf[rd_addr]. rd_addr >= MAX_LEN returns 8'h00.
// TESTING
//  1 Send A5 03 11 22 33 03 -> frm_valid=1 the cycle after the last byte, frm_len=3,
//    rd_dat at rd_addr 0/1/2 = 11/22/33, frm_cnt=1. Pulse frm_ack -> frm_valid=0, busy=0.
//  2 Send A5 02 10 20 31 (expected 32) -> err_chk pulses for 1 cycle, frm_valid=0, err_cnt=1, next A5 frame accepted.
//  3 Send A5 00 and A5 11 (MAX_LEN=16) -> err_len pulses once for each, state returns to S_IDLE, no buffer write.
//  4 Send A5 03 11, then idle for TIMEOUT_CYC cycles -> err_to pulses once, busy=0. Bytes 22 33 03 that follow are ignored.
//  5 Hold a good frame unacked, send 55 -> err_ovr pulses, buffer and frm_len unchanged.
//    Send byte and frm_ack in the same cycle -> frm_valid=0 and err_ovr=1.
//  6 Hold rx_ok high 3 cycles per byte for frame 1 -> identical result to scenario 1.
//    Assert rstn=0 mid-payload -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receiver: SYNC, LEN, PAYLOAD[LEN], CHK.
// Holds one good payload until the consumer acknowledges it; reports framing errors.
module uart_frame_parser #(
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned AW          = 4,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 250000
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [7:0]    rx_dat,
    input  logic          rx_ok,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_dat,
    output logic [AW:0]   frm_len,
    output logic          frm_valid,
    input  logic          frm_ack,
    output logic          busy,
    output logic          err_chk,
    output logic          err_len,
    output logic          err_to,
    output logic          err_ovr,
    output logic [7:0]    frm_cnt,
    output logic [7:0]    err_cnt
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          rx_ok_d;
    logic          byte_evt;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timed;
    logic          time_up;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [7:0]    mem [DEPTH];

    logic [LW-1:0] frm_len_d;
    logic          frm_valid_d;
    logic          busy_d;
    logic          err_chk_d, err_len_d, err_to_d, err_ovr_d;
    logic [7:0]    frm_cnt_d, err_cnt_d;

    // One byte per rising edge of the receiver strobe
    assign byte_evt = rx_ok & ~rx_ok_d;
    assign timed    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
    assign time_up  = timed && (tcnt_q == TW'(TIMEOUT_CYC - 1));

    // Entries at or above MAX_LEN are never written, so they read back as zero
    assign rd_dat = mem[rd_addr];

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        chk_d       = chk_q;
        tcnt_d      = '0;
        wr_en       = 1'b0;
        wr_idx      = idx_q[AW-1:0];
        frm_len_d   = frm_len;
        frm_valid_d = frm_valid;
        frm_cnt_d   = frm_cnt;
        err_chk_d   = 1'b0;
        err_len_d   = 1'b0;
        err_to_d    = 1'b0;
        err_ovr_d   = 1'b0;
        err_cnt_d   = err_cnt;

        if (timed) begin
            tcnt_d = tcnt_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (byte_evt && (rx_dat == SYNC_BYTE)) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (byte_evt) begin
                    tcnt_d = '0;
                    if ((rx_dat != 8'd0) && (32'(rx_dat) <= MAX_LEN)) begin
                        len_d   = LW'(rx_dat);
                        chk_d   = rx_dat;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end else if (time_up) begin
                    tcnt_d   = '0;
                    err_to_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_DATA: begin
                if (byte_evt) begin
                    tcnt_d = '0;
                    wr_en  = 1'b1;
                    chk_d  = chk_q ^ rx_dat;
                    idx_d  = idx_q + LW'(1);
                    if (idx_d == len_q) begin
                        state_d = S_CHK;
                    end
                end else if (time_up) begin
                    tcnt_d   = '0;
                    err_to_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_CHK: begin
                if (byte_evt) begin
                    tcnt_d = '0;
                    if (rx_dat == chk_q) begin
                        frm_len_d   = len_q;
                        frm_valid_d = 1'b1;
                        frm_cnt_d   = frm_cnt + 8'd1;
                        state_d     = S_DONE;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end else if (time_up) begin
                    tcnt_d   = '0;
                    err_to_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_DONE: begin
                // Buffer is frozen; any byte here is dropped even if ack arrives together
                if (byte_evt) begin
                    err_ovr_d = 1'b1;
                end
                if (frm_ack) begin
                    frm_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((err_chk_d || err_len_d || err_to_d || err_ovr_d) && (err_cnt != 8'hFF)) begin
            err_cnt_d = err_cnt + 8'd1;
        end

        busy_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHK);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            rx_ok_d   <= 1'b0;
            len_q     <= '0;
            idx_q     <= '0;
            chk_q     <= '0;
            tcnt_q    <= '0;
            frm_len   <= '0;
            frm_valid <= 1'b0;
            busy      <= 1'b0;
            err_chk   <= 1'b0;
            err_len   <= 1'b0;
            err_to    <= 1'b0;
            err_ovr   <= 1'b0;
            frm_cnt   <= '0;
            err_cnt   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rx_ok_d   <= rx_ok;
            len_q     <= len_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            tcnt_q    <= tcnt_d;
            frm_len   <= frm_len_d;
            frm_valid <= frm_valid_d;
            busy      <= busy_d;
            err_chk   <= err_chk_d;
            err_len   <= err_len_d;
            err_to    <= err_to_d;
            err_ovr   <= err_ovr_d;
            frm_cnt   <= frm_cnt_d;
            err_cnt   <= err_cnt_d;
            if (wr_en) begin
                mem[wr_idx] <= rx_dat;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_frame_parser;

    localparam int TO   = 40;
    localparam int MAXL = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] rx_dat;
    logic       rx_ok;
    logic [3:0] rd_addr;
    logic [7:0] rd_dat;
    logic [4:0] frm_len;
    logic       frm_valid;
    logic       frm_ack;
    logic       busy;
    logic       err_chk, err_len, err_to, err_ovr;
    logic [7:0] frm_cnt, err_cnt;

    uart_frame_parser #(
        .MAX_LEN(MAXL), .AW(4), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .rx_dat(rx_dat), .rx_ok(rx_ok),
        .rd_addr(rd_addr), .rd_dat(rd_dat), .frm_len(frm_len),
        .frm_valid(frm_valid), .frm_ack(frm_ack), .busy(busy),
        .err_chk(err_chk), .err_len(err_len), .err_to(err_to), .err_ovr(err_ovr),
        .frm_cnt(frm_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic rand_ack = 1'b0;

    // Reference model: bytes collected since SYNC, the held frame, and counters
    logic       m_prev_ok, m_in, m_held;
    int         m_idle;
    logic [7:0] mq[$];
    logic [7:0] mbuf [16];
    logic [4:0] e_len;
    logic       e_chk, e_lerr, e_to, e_ovr;
    logic [7:0] e_fcnt, e_ecnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_prev_ok = 0; m_in = 0; m_held = 0; m_idle = 0;
        mq.delete();
        for (int i = 0; i < 16; i++) mbuf[i] = 8'h00;
        e_len = 0; e_chk = 0; e_lerr = 0; e_to = 0; e_ovr = 0;
        e_fcnt = 0; e_ecnt = 0;
    endtask

    task automatic model_step(input logic ok, input logic [7:0] d, input logic ack);
        logic evt;
        int L;
        logic [7:0] x;
        evt = ok && !m_prev_ok;
        m_prev_ok = ok;
        e_chk = 0; e_lerr = 0; e_to = 0; e_ovr = 0;
        if (m_held) begin
            if (evt) e_ovr = 1;
            if (ack) m_held = 0;
        end else if (!m_in) begin
            if (evt && d == SYNC) begin
                m_in = 1; mq.delete(); m_idle = 0;
            end
        end else if (evt) begin
            m_idle = 0;
            mq.push_back(d);
            L = int'(mq[0]);
            if (mq.size() == 1) begin
                if (L == 0 || L > MAXL) begin e_lerr = 1; m_in = 0; end
            end else if (mq.size() <= L + 1) begin
                mbuf[mq.size() - 2] = d;
            end else begin
                x = 8'h00;
                for (int i = 0; i <= L; i++) x = x ^ mq[i];
                if (x == d) begin
                    m_held = 1; e_len = 5'(L); e_fcnt = e_fcnt + 8'd1;
                end else begin
                    e_chk = 1;
                end
                m_in = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin e_to = 1; m_in = 0; end
        end
        if ((e_chk || e_lerr || e_to || e_ovr) && e_ecnt != 8'hFF) e_ecnt = e_ecnt + 8'd1;
    endtask

    task automatic check_all();
        chk("frm_valid", 32'(frm_valid), 32'(m_held));
        chk("frm_len",   32'(frm_len),   32'(e_len));
        chk("busy",      32'(busy),      32'(m_in));
        chk("err_chk",   32'(err_chk),   32'(e_chk));
        chk("err_len",   32'(err_len),   32'(e_lerr));
        chk("err_to",    32'(err_to),    32'(e_to));
        chk("err_ovr",   32'(err_ovr),   32'(e_ovr));
        chk("frm_cnt",   32'(frm_cnt),   32'(e_fcnt));
        chk("err_cnt",   32'(err_cnt),   32'(e_ecnt));
        chk("rd_dat",    32'(rd_dat),    32'(mbuf[rd_addr]));
    endtask

    task automatic cycle(input logic ok, input logic [7:0] d, input logic ack);
        rx_ok   = ok;
        rx_dat  = d;
        frm_ack = ack | (rand_ack && ($urandom_range(0, 5) == 0));
        rd_addr = 4'($urandom_range(0, 15));
        model_step(rx_ok, rx_dat, frm_ack);
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input logic [7:0] b, input int hold, input int gap);
        for (int i = 0; i < hold; i++) cycle(1'b1, b, 1'b0);
        for (int i = 0; i < gap; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string name);
        rd_addr = a;
        #1;
        chk(name, 32'(rd_dat), 32'(exp));
    endtask

    task automatic send_frame(input int len, input logic bad_chk, input int hold);
        logic [7:0] c;
        logic [7:0] p;
        c = 8'(len);
        send(SYNC, hold, 1);
        send(8'(len), hold, 1);
        for (int i = 0; i < len; i++) begin
            p = 8'($urandom_range(0, 255));
            c = c ^ p;
            send(p, hold, 1);
        end
        send(bad_chk ? ~c : c, hold, 1);
    endtask

    task automatic send_frame1(input int hold);
        send(SYNC, hold, 1); send(8'h03, hold, 1);
        send(8'h11, hold, 1); send(8'h22, hold, 1); send(8'h33, hold, 1);
        for (int i = 0; i < hold; i++) cycle(1'b1, 8'h03, 1'b0);
    endtask

    initial begin
        int seen;
        int kind;
        int len;
        rstn = 1'b0; rx_ok = 1'b0; rx_dat = 8'h00; frm_ack = 1'b0; rd_addr = 4'h0;
        model_reset();
        @(negedge clk);
        chk("reset_frm_valid", 32'(frm_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_cnts", {16'h0, frm_cnt, err_cnt}, 0);
        check_all();
        rstn = 1'b1;

        // Scenario 1: good 3-byte frame
        send_frame1(1);
        chk("s1_valid", 32'(frm_valid), 1);
        chk("s1_len", 32'(frm_len), 3);
        chk("s1_frm_cnt", 32'(frm_cnt), 1);
        peek(4'd0, 8'h11, "s1_rd0"); peek(4'd1, 8'h22, "s1_rd1"); peek(4'd2, 8'h33, "s1_rd2");
        cycle(1'b0, 8'h00, 1'b1);
        chk("s1_ack_valid", 32'(frm_valid), 0);
        chk("s1_ack_busy", 32'(busy), 0);

        // Scenario 2: checksum error, then a good frame
        send(SYNC, 1, 1); send(8'h02, 1, 1); send(8'h10, 1, 1); send(8'h20, 1, 1);
        cycle(1'b1, 8'h31, 1'b0);
        chk("s2_err_chk", 32'(err_chk), 1);
        chk("s2_err_cnt", 32'(err_cnt), 1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("s2_err_chk_pulse", 32'(err_chk), 0);
        send_frame(2, 1'b0, 1);
        chk("s2_next_ok", 32'(frm_valid), 1);
        cycle(1'b0, 8'h00, 1'b1);

        // Scenario 3: invalid LEN values
        send(SYNC, 1, 1); cycle(1'b1, 8'h00, 1'b0);
        chk("s3_len0", 32'(err_len), 1);
        cycle(1'b0, 8'h00, 1'b0);
        send(SYNC, 1, 1); cycle(1'b1, 8'h11, 1'b0);
        chk("s3_len17", 32'(err_len), 1);
        chk("s3_busy", 32'(busy), 0);
        cycle(1'b0, 8'h00, 1'b0);

        // Scenario 4: timeout mid-payload, trailing bytes ignored
        send(SYNC, 1, 1); send(8'h03, 1, 1); send(8'h11, 1, 0);
        seen = 0;
        for (int i = 0; i < TO + 5; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            if (err_to) seen++;
        end
        chk("s4_err_to_once", 32'(seen), 1);
        chk("s4_busy", 32'(busy), 0);
        send(8'h22, 1, 1); send(8'h33, 1, 1); send(8'h03, 1, 1);
        chk("s4_ignored", {busy, frm_valid}, 0);

        // Scenario 5: overrun while holding, then byte together with ack
        send(SYNC, 1, 1); send(8'h01, 1, 1); send(8'h7E, 1, 1); send(8'h7F, 1, 1);
        cycle(1'b1, 8'h55, 1'b0);
        chk("s5_ovr", 32'(err_ovr), 1);
        chk("s5_len_kept", 32'(frm_len), 1);
        peek(4'd0, 8'h7E, "s5_buf_kept");
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h55, 1'b1);
        chk("s5_ack_ovr", 32'(err_ovr), 1);
        chk("s5_ack_valid", 32'(frm_valid), 0);
        cycle(1'b0, 8'h00, 1'b0);

        // Scenario 6: stretched strobes, then reset mid-payload
        send_frame1(3);
        chk("s6_valid", 32'(frm_valid), 1);
        chk("s6_len", 32'(frm_len), 3);
        peek(4'd2, 8'h33, "s6_rd2");
        cycle(1'b0, 8'h00, 1'b1);
        send(SYNC, 1, 1); send(8'h03, 1, 1); send(8'h44, 1, 1);
        rstn = 1'b0; rx_ok = 1'b0;
        #1;
        chk("s6_rst_outs", {frm_valid, busy, frm_len, frm_cnt, err_cnt}, 0);
        peek(4'd0, 8'h00, "s6_rst_buf");
        model_reset();
        check_all();
        @(negedge clk);
        rstn = 1'b1;

        // frm_cnt wraps, err_cnt saturates
        for (int f = 0; f < 256; f++) begin
            send_frame(1, 1'b0, 1);
            cycle(1'b0, 8'h00, 1'b1);
            if (f == 254) chk("frm_cnt_255", 32'(frm_cnt), 255);
        end
        chk("frm_cnt_wrap", 32'(frm_cnt), 0);
        for (int f = 0; f < 260; f++) begin
            send(SYNC, 1, 1); send(8'h00, 1, 1);
        end
        chk("err_cnt_sat", 32'(err_cnt), 255);

        // Randomized traffic with random acks and overruns
        rand_ack = 1'b1;
        for (int it = 0; it < 300; it++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: send_frame($urandom_range(1, MAXL), 1'b0, $urandom_range(1, 3));
                1: send_frame($urandom_range(1, MAXL), 1'b1, $urandom_range(1, 3));
                2: begin
                    send(SYNC, 1, $urandom_range(1, 2));
                    send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)), 1, 1);
                end
                3: begin
                    len = $urandom_range(1, MAXL);
                    send(SYNC, 1, 1); send(8'(len), 1, 1);
                    for (int i = 0; i < $urandom_range(0, len - 1); i++)
                        send(8'($urandom_range(0, 255)), 1, 1);
                    for (int i = 0; i < TO + 3; i++) cycle(1'b0, 8'h00, 1'b0);
                end
                4: send(8'($urandom_range(0, 255)), $urandom_range(1, 3), $urandom_range(1, 2));
                default: for (int i = 0; i < $urandom_range(1, 6); i++) cycle(1'b0, 8'h00, 1'b0);
            endcase
        end
        rand_ack = 1'b0;
        cycle(1'b0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
